// File: rtl/rs_interleaver_pkg.sv
// Interleaver-side shared constants consumed by the TX framing stage.
// Combinational only; no latency.
// No handshake; constants only.
package rs_interleaver_pkg;

    localparam int CODEWORD_BYTES = 255;

endpackage

// File: rtl/tx_frame_pkg.sv
// TX channel-frame constants, FSM state type and the PN randomizer step function.
// Combinational only; no latency.
// No handshake; constants and a pure function.
package tx_frame_pkg;

    import rs_interleaver_pkg::*;

    localparam logic [31:0] ASM_WORD    = 32'h1ACF_FC1D;
    localparam int          ASM_BYTES   = 4;
    localparam int          FRAME_BYTES = ASM_BYTES + CODEWORD_BYTES;
    localparam logic [7:0]  PN_SEED     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // The state byte is the next 8 sequence bits, oldest bit in the MSB.
    // New bit = a[n] ^ a[n+3] ^ a[n+5] ^ a[n+7] for x^8+x^7+x^5+x^3+1.
    function automatic logic [7:0] pn_advance8(input logic [7:0] s);
        logic [7:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = {r[6:0], r[7] ^ r[4] ^ r[2] ^ r[0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_framer_pn_randomizer.sv
// CCSDS pseudo-randomizer: 8 sequence bits per step, MSB first (module pn_randomizer).
// pn_byte is the current state; advance/seed take effect on the next clock.
// No handshake; the parent decides when to step or reseed.
// Built only when SYNC_FRAMER_RANDOMIZER_EN is defined.
// Ports: clk, rst_n, seed (reload all-ones), advance (step 8 bits), pn_byte (current PN byte).
`ifdef SYNC_FRAMER_RANDOMIZER_EN
module pn_randomizer
    import tx_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seed,
    input  logic       advance,
    output logic [7:0] pn_byte
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= PN_SEED;
        end else if (seed) begin
            lfsr_q <= PN_SEED;
        end else if (advance) begin
            lfsr_q <= pn_advance8(lfsr_q);
        end
    end

    assign pn_byte = lfsr_q;

endmodule
`endif

// File: rtl/sync_framer.sv
// Prepends the 4-byte ASM to each 255-byte codeword, optionally PN-randomizing codeword bytes.
// Latency: accepted byte appears on m_tdata the next cycle; 259 beats per frame, 260-cycle minimum period.
// Backpressure: single registered output slot; m_tready low holds the beat and stalls SYNC/DATA progress.
// Ports: s_t* byte stream in (s_tlast checked, not trusted), m_t* frame stream out
//        (m_tuser marks ASM beats, m_tlast the 259th beat), err_framing pulse, busy.
// Build option: SYNC_FRAMER_RANDOMIZER_EN enables the randomizer; otherwise bytes pass unchanged.
module sync_framer #(
    parameter int          BLOCK_BYTES = rs_interleaver_pkg::CODEWORD_BYTES,
    parameter logic [31:0] ASM_WORD    = tx_frame_pkg::ASM_WORD,
    parameter int          ASM_BYTES   = tx_frame_pkg::ASM_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       m_tuser,
    output logic       err_framing,
    output logic       busy
);

    import tx_frame_pkg::*;

    state_e     state_q;
    logic [8:0] cnt_q;
    logic [7:0] m_tdata_q;
    logic       m_tvalid_q;
    logic       m_tlast_q;
    logic       m_tuser_q;
    logic       err_q;

    logic       slot_free;
    logic       accept;
    logic       last_asm;
    logic       last_byte;
    logic [7:0] asm_byte;
    logic [7:0] pn_byte;

    assign slot_free = !m_tvalid_q || m_tready;
    assign s_tready  = (state_q == ST_DATA) && slot_free;
    assign accept    = s_tready && s_tvalid;
    assign last_asm  = (cnt_q == 9'(ASM_BYTES - 1));
    assign last_byte = (cnt_q == 9'(BLOCK_BYTES - 1));

    // Marker goes out MSB byte first: cnt 0 selects bits [31:24].
    assign asm_byte = 8'(ASM_WORD >> (5'd24 - {cnt_q[1:0], 3'b000}));

`ifdef SYNC_FRAMER_RANDOMIZER_EN
    logic pn_seed;

    // Reseed as the last marker byte is loaded so the first codeword byte sees 8'hFF.
    assign pn_seed = (state_q == ST_SYNC) && slot_free && last_asm;

    pn_randomizer u_pn (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (pn_seed),
        .advance (accept),
        .pn_byte (pn_byte)
    );
`else
    assign pn_byte = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            m_tdata_q  <= 8'h00;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // A consumed or empty slot drains unless something is loaded below.
            if (slot_free) begin
                m_tvalid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    // Only start a marker once codeword data is actually pending.
                    if (s_tvalid) begin
                        state_q <= ST_SYNC;
                        cnt_q   <= '0;
                    end
                end
                ST_SYNC: begin
                    if (slot_free) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= asm_byte;
                        m_tuser_q  <= 1'b1;
                        m_tlast_q  <= 1'b0;
                        if (last_asm) begin
                            state_q <= ST_DATA;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 9'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= s_tdata ^ pn_byte;
                        m_tuser_q  <= 1'b0;
                        m_tlast_q  <= last_byte;
                        // The local count owns frame boundaries; s_tlast is only audited.
                        err_q      <= (s_tlast != last_byte);
                        if (last_byte) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 9'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign m_tdata     = m_tdata_q;
    assign m_tvalid    = m_tvalid_q;
    assign m_tlast     = m_tlast_q;
    assign m_tuser     = m_tuser_q;
    assign err_framing = err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
